// File: rtl/spmv_pkg.sv
// Shared types and arithmetic helper for the SpMV row accumulator.
// Build option: ACC_SAT_EN selects saturating accumulation instead of wrap-around.
package spmv_pkg;

    localparam int unsigned ROW_W  = 10;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned ACC_W  = 72;

    typedef logic [ROW_W-1:0]         row_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    typedef struct packed {
        row_t row;
        acc_t sum;
    } result_t;

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    typedef struct packed {
        acc_t sum;
        logic sat;
    } add_t;

    // sat flags signed overflow; the sum only clamps when ACC_SAT_EN is defined.
    function automatic add_t acc_add(acc_t a, acc_t b);
        logic [ACC_W:0] full;
        add_t           r;
        full  = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        r.sat = full[ACC_W] ^ full[ACC_W-1];
        r.sum = full[ACC_W-1:0];
`ifdef ACC_SAT_EN
        if (r.sat) begin
            r.sum = full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/spmv_row_accum_if.sv
// Beat input stream and result output stream of the row accumulator.
// Build option: ACC_SAT_EN adds the sticky sat flag.
interface spmv_row_accum_if;
    import spmv_pkg::*;

    logic  in_valid;
    logic  in_zeros;
    logic  in_last;
    row_t  in_row;
    prod_t in_op1;
    prod_t in_op2;
    logic  out_ready;
    logic  out_valid;
    row_t  out_row;
    acc_t  out_data;
    logic  busy;
    logic  ovf;
`ifdef ACC_SAT_EN
    logic  sat;
`endif

    modport slave (
        input  in_valid, in_zeros, in_last, in_row, in_op1, in_op2, out_ready,
        output out_valid, out_row, out_data, busy, ovf
`ifdef ACC_SAT_EN
        , output sat
`endif
    );

    modport master (
        output in_valid, in_zeros, in_last, in_row, in_op1, in_op2, out_ready,
        input  out_valid, out_row, out_data, busy, ovf
`ifdef ACC_SAT_EN
        , input sat
`endif
    );

endinterface

// File: rtl/spmv_result_fifo.sv
// Two-write / one-read result FIFO with a registered head and sticky overflow flag.
// Writes that find no free slot (after the same-cycle pop) are dropped; port 0 has priority.
module spmv_result_fifo
    import spmv_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    push0_i,
    input  result_t wdata0_i,
    input  logic    push1_i,
    input  result_t wdata1_i,
    input  logic    ready_i,
    output logic    valid_o,
    output result_t head_o,
    output logic    ovf_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    result_t mem_q [Depth];
    ptr_t    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_idx1;
    cnt_t    count_q, count_d, count_pop, free;
    logic    pop, acc0, acc1;
    logic    ovf_q, ovf_d;
    logic    valid_q, valid_d;
    result_t head_q, head_d;

    always_comb begin
        pop       = valid_q & ready_i;
        count_pop = count_q - cnt_t'(pop);
        free      = cnt_t'(Depth) - count_pop;
        acc0      = push0_i && (free != '0);
        acc1      = push1_i && (free > cnt_t'(acc0));
        wr_idx1   = acc0 ? ptr_t'(wr_ptr_q + ptr_t'(1)) : wr_ptr_q;
        ovf_d     = ovf_q | (push0_i & ~acc0) | (push1_i & ~acc1);
        rd_ptr_d  = rd_ptr_q + ptr_t'(pop);
        wr_ptr_d  = wr_ptr_q + ptr_t'(acc0) + ptr_t'(acc1);
        count_d   = count_pop + cnt_t'(acc0) + cnt_t'(acc1);
        valid_d   = (count_d != '0);
        // A surviving entry is already in memory; otherwise the head comes straight from a write.
        if (count_pop != '0) begin
            head_d = mem_q[rd_ptr_d];
        end else if (acc0) begin
            head_d = wdata0_i;
        end else if (acc1) begin
            head_d = wdata1_i;
        end else begin
            head_d = head_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc0) begin
            mem_q[wr_ptr_q] <= wdata0_i;
        end
        if (acc1) begin
            mem_q[wr_idx1] <= wdata1_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    assign valid_o = valid_q;
    assign head_o  = head_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/spmv_row_accum.sv
// Sums CSR partial products per row and queues one (row, sum) result per closed row.
// Build option: ACC_SAT_EN enables saturating sums and the sticky sat output.
module spmv_row_accum
    import spmv_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    spmv_row_accum_if.slave         bus_io
);

    state_e  state_q, state_d;
    row_t    cur_row_q, cur_row_d;
    acc_t    acc_q, acc_d;
    add_t    beat_r, accum_r;
    acc_t    beat_val;
    logic    same_row;
    logic    push0, push1;
    result_t wdata0, wdata1;
    logic    fifo_valid;
    result_t fifo_head;
    logic    fifo_ovf;

    assign beat_r   = acc_add(acc_t'(bus_io.in_op1), acc_t'(bus_io.in_op2));
    assign beat_val = bus_io.in_zeros ? '0 : beat_r.sum;
    assign accum_r  = acc_add(acc_q, beat_val);
    assign same_row = (bus_io.in_row == cur_row_q);

    always_comb begin
        state_d   = state_q;
        cur_row_d = cur_row_q;
        acc_d     = acc_q;
        push0     = 1'b0;
        push1     = 1'b0;
        wdata0    = '0;
        wdata1    = '0;
        if (bus_io.in_valid) begin
            case (state_q)
                StIdle: begin
                    cur_row_d = bus_io.in_row;
                    acc_d     = beat_val;
                    state_d   = StAccum;
                    if (bus_io.in_last) begin
                        push0   = 1'b1;
                        wdata0  = '{row: bus_io.in_row, sum: beat_val};
                        state_d = StIdle;
                    end
                end
                StAccum: begin
                    if (same_row) begin
                        acc_d = accum_r.sum;
                        if (bus_io.in_last) begin
                            push0   = 1'b1;
                            wdata0  = '{row: cur_row_q, sum: accum_r.sum};
                            state_d = StIdle;
                        end
                    end else begin
                        // Row change closes the open row; with last the new row closes too.
                        push0     = 1'b1;
                        wdata0    = '{row: cur_row_q, sum: acc_q};
                        cur_row_d = bus_io.in_row;
                        acc_d     = beat_val;
                        if (bus_io.in_last) begin
                            push1   = 1'b1;
                            wdata1  = '{row: bus_io.in_row, sum: beat_val};
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cur_row_q <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_row_q <= cur_row_d;
            acc_q     <= acc_d;
        end
    end

`ifdef ACC_SAT_EN
    logic sat_q, sat_hit;

    assign sat_hit = bus_io.in_valid &
                     ((beat_r.sat & ~bus_io.in_zeros) |
                      ((state_q == StAccum) & same_row & accum_r.sat));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_q <= 1'b0;
        end else if (sat_hit) begin
            sat_q <= 1'b1;
        end
    end

    assign bus_io.sat = sat_q;
`else
    logic unused_sat;
    assign unused_sat = beat_r.sat ^ accum_r.sat;
`endif

    spmv_result_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push0_i  (push0),
        .wdata0_i (wdata0),
        .push1_i  (push1),
        .wdata1_i (wdata1),
        .ready_i  (bus_io.out_ready),
        .valid_o  (fifo_valid),
        .head_o   (fifo_head),
        .ovf_o    (fifo_ovf)
    );

    assign bus_io.out_valid = fifo_valid;
    assign bus_io.out_row   = fifo_head.row;
    assign bus_io.out_data  = fifo_head.sum;
    assign bus_io.ovf       = fifo_ovf;
    assign bus_io.busy      = (state_q == StAccum) | fifo_valid;

endmodule
